// File: rtl/acct_table_ctrl.sv
// Access-control table: shadow entries are programmed over a single-cycle register port
// and copied atomically to the active bank (acc_ctrl_o) on commit, under per-group locks.
module acct_table_ctrl #(
   parameter int unsigned NB_PERIPHERALS = 9,
   parameter int unsigned ENTRY_W        = 32,
   parameter int unsigned GROUP_SIZE     = 3,
   parameter int unsigned ADDR_W         = 64,
   localparam int unsigned NB_GROUPS     = (NB_PERIPHERALS + GROUP_SIZE - 1) / GROUP_SIZE
) (
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic                                acct_ctrl_i,
   input  logic [2*NB_GROUPS-1:0]              reglk_ctrl_i,
   input  logic                                req_i,
   input  logic                                we_i,
   input  logic [ADDR_W-1:0]                   addr_i,
   input  logic [63:0]                         wdata_i,
   output logic                                rvalid_o,
   output logic [63:0]                         rdata_o,
   output logic                                err_o,
   output logic [NB_PERIPHERALS*ENTRY_W-1:0]   acc_ctrl_o
);

   localparam logic [7:0] CMD_IDX    = 8'h80;
   localparam logic [7:0] STICKY_IDX = 8'h81;
   localparam logic [7:0] VIOL_IDX   = 8'h82;
   localparam logic [7:0] STATUS_IDX = 8'h83;

   logic [ENTRY_W-1:0]        shadow_q [NB_PERIPHERALS];
   logic [ENTRY_W-1:0]        shadow_d [NB_PERIPHERALS];
   logic [ENTRY_W-1:0]        active_q [NB_PERIPHERALS];
   logic [ENTRY_W-1:0]        active_d [NB_PERIPHERALS];
   logic [NB_GROUPS-1:0]      sticky_q, sticky_d;
   logic [15:0]               viol_q, viol_d;
   logic                      rvalid_q, rvalid_d;
   logic [63:0]               rdata_q, rdata_d;
   logic                      err_q, err_d;

   logic [NB_GROUPS-1:0]      wlock_grp;
   logic [NB_PERIPHERALS-1:0] wlock_ent, rlock_ent, diff_ent;
   logic [7:0]                word;
   logic                      pending;
   logic                      hit_shadow, sel_rlock, sel_wlock, viol;
   logic [ENTRY_W-1:0]        sel_data;
   logic                      unused_bits;

   assign word        = addr_i[10:3];
   assign pending     = |diff_ent;
   assign unused_bits = ^{addr_i, wdata_i};

   for (genvar gi = 0; gi < NB_GROUPS; gi++) begin : g_grp
      assign wlock_grp[gi] = reglk_ctrl_i[2*gi+1] | sticky_q[gi];
   end

   for (genvar gi = 0; gi < NB_PERIPHERALS; gi++) begin : g_ent
      assign wlock_ent[gi] = wlock_grp[gi / GROUP_SIZE];
      assign rlock_ent[gi] = reglk_ctrl_i[2*(gi / GROUP_SIZE)];
      assign diff_ent[gi]  = shadow_q[gi] != active_q[gi];
      assign acc_ctrl_o[gi*ENTRY_W +: ENTRY_W] = active_q[gi];
   end

   always_comb begin
      shadow_d   = shadow_q;
      active_d   = active_q;
      sticky_d   = sticky_q;
      viol_d     = viol_q;
      rvalid_d   = req_i;
      rdata_d    = '0;
      err_d      = 1'b0;
      viol       = 1'b0;
      hit_shadow = 1'b0;
      sel_rlock  = 1'b0;
      sel_wlock  = 1'b0;
      sel_data   = '0;

      for (int i = 0; i < NB_PERIPHERALS; i++) begin
         if (word == 8'(i)) begin
            hit_shadow = 1'b1;
            sel_rlock  = rlock_ent[i];
            sel_wlock  = wlock_ent[i];
            sel_data   = shadow_q[i];
         end
      end

      if (req_i) begin
         if (!acct_ctrl_i) begin
            err_d = 1'b1;
         end else if (hit_shadow) begin
            if (we_i) begin
               if (sel_wlock) begin
                  err_d = 1'b1;
                  viol  = 1'b1;
               end else begin
                  for (int i = 0; i < NB_PERIPHERALS; i++) begin
                     if (word == 8'(i)) shadow_d[i] = wdata_i[ENTRY_W-1:0];
                  end
               end
            end else if (sel_rlock) begin
               err_d = 1'b1;
               viol  = 1'b1;
            end else begin
               rdata_d[ENTRY_W-1:0] = sel_data;
            end
         end else begin
            case (word)
               CMD_IDX: begin
                  // Commit takes priority; locked groups keep both banks untouched.
                  if (we_i) begin
                     for (int i = 0; i < NB_PERIPHERALS; i++) begin
                        if (!wlock_ent[i]) begin
                           if (wdata_i[0])      active_d[i] = shadow_q[i];
                           else if (wdata_i[1]) shadow_d[i] = active_q[i];
                        end
                     end
                  end
               end
               STICKY_IDX: begin
                  if (we_i) sticky_d = sticky_q | wdata_i[NB_GROUPS-1:0];
                  else      rdata_d[NB_GROUPS-1:0] = sticky_q;
               end
               VIOL_IDX: begin
                  if (we_i) viol_d = '0;
                  else      rdata_d[15:0] = viol_q;
               end
               STATUS_IDX: begin
                  if (we_i) err_d = 1'b1;
                  else      rdata_d[0] = pending;
               end
               default: err_d = 1'b1;
            endcase
         end
      end

      if (viol && viol_q != 16'hFFFF) viol_d = viol_q + 16'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NB_PERIPHERALS; i++) begin
            shadow_q[i] <= '1;
            active_q[i] <= '1;
         end
         sticky_q <= '0;
         viol_q   <= '0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         sticky_q <= sticky_d;
         viol_q   <= viol_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign err_o    = err_q;

endmodule

// File: tb/tb_acct_table_ctrl.sv
// Directed bench for acct_table_ctrl: requests push expected responses to a queue,
// a negedge monitor pops and compares them against rvalid_o/rdata_o/err_o/acc_ctrl_o.
module tb_acct_table_ctrl;

   localparam int NB = 9;
   localparam int EW = 32;
   localparam int NG = 3;
   localparam int AW = NB * EW;

   localparam int W_CMD    = 'h80;
   localparam int W_STICKY = 'h81;
   localparam int W_VIOL   = 'h82;
   localparam int W_STATUS = 'h83;

   typedef struct {
      logic [63:0]   rdata;
      logic          err;
      logic [AW-1:0] acc;
      string         name;
   } exp_t;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          acct_ctrl_i = 1'b1;
   logic [2*NG-1:0] reglk_ctrl_i = '0;
   logic          req_i = 1'b0;
   logic          we_i = 1'b0;
   logic [63:0]   addr_i = '0;
   logic [63:0]   wdata_i = '0;
   logic          rvalid_o;
   logic [63:0]   rdata_o;
   logic          err_o;
   logic [AW-1:0] acc_ctrl_o;

   exp_t          sb_q[$];
   logic [AW-1:0] exp_acc;
   int            n_cmp = 0;
   int            n_bad = 0;

   acct_table_ctrl #(
      .NB_PERIPHERALS(NB), .ENTRY_W(EW), .GROUP_SIZE(3), .ADDR_W(64)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .acct_ctrl_i(acct_ctrl_i), .reglk_ctrl_i(reglk_ctrl_i),
      .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o), .acc_ctrl_o(acc_ctrl_o)
   );

   initial forever #5 clk_i = ~clk_i;

   // Monitor: every response must match the oldest outstanding expectation.
   initial forever begin
      @(negedge clk_i);
      if (rvalid_o) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_rvalid: got rdata=%h err=%b, required no response", rdata_o, err_o);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (rdata_o !== e.rdata || err_o !== e.err || acc_ctrl_o !== e.acc) begin
               n_bad++;
               $display("FAIL %s: got rdata=%h err=%b acc=%h, required rdata=%h err=%b acc=%h",
                        e.name, rdata_o, err_o, acc_ctrl_o, e.rdata, e.err, e.acc);
            end else begin
               $display("ok   %s: rdata=%h err=%b", e.name, rdata_o, err_o);
            end
         end
      end
   end

   task automatic req(input logic we, input int word, input logic [63:0] wd,
                      input logic [63:0] er, input logic ee, input string name);
      exp_t e;
      @(negedge clk_i);
      req_i   = 1'b1;
      we_i    = we;
      addr_i  = 64'(word) << 3;
      wdata_i = wd;
      e.rdata = er;
      e.err   = ee;
      e.acc   = exp_acc;
      e.name  = name;
      sb_q.push_back(e);
   endtask

   task automatic wr(input int word, input logic [63:0] wd, input logic ee, input string name);
      req(1'b1, word, wd, 64'd0, ee, name);
   endtask

   task automatic rd(input int word, input logic [63:0] er, input logic ee, input string name);
      req(1'b0, word, 64'd0, er, ee, name);
   endtask

   task automatic set_ctrl(input logic en, input logic [2*NG-1:0] lk);
      @(negedge clk_i);
      req_i        = 1'b0;
      acct_ctrl_i  = en;
      reglk_ctrl_i = lk;
   endtask

   task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req_v);
      n_cmp++;
      if (act !== req_v) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, req_v);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic set_acc(input int idx, input logic [EW-1:0] v);
      exp_acc[idx*EW +: EW] = v;
   endtask

   initial begin
      exp_acc = '1;
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      chk("reset_rvalid", AW'(rvalid_o), AW'(1'b0));
      chk("reset_rdata",  AW'(rdata_o),  AW'(64'd0));
      chk("reset_err",    AW'(err_o),    AW'(1'b0));
      chk("reset_acc",    acc_ctrl_o,    {AW{1'b1}});

      rd(0, 64'hFFFF_FFFF, 1'b0, "rst_read_w0");
      wr(1, 64'hA5, 1'b0, "write_w1");
      rd(W_STATUS, 64'd1, 1'b0, "status_pending");
      set_acc(1, 32'hA5);
      wr(W_CMD, 64'd1, 1'b0, "commit_w1");
      rd(W_STATUS, 64'd0, 1'b0, "status_clean");
      rd(1, 64'hA5, 1'b0, "read_w1");

      set_ctrl(1'b1, 6'b001000);
      wr(4, 64'h1234, 1'b1, "wlock_w4");
      rd(4, 64'hFFFF_FFFF, 1'b0, "w4_unchanged");
      rd(W_VIOL, 64'd1, 1'b0, "viol_one");
      set_ctrl(1'b1, 6'b000000);
      wr(4, 64'h1234, 1'b0, "unlocked_w4");
      rd(4, 64'h1234, 1'b0, "read_w4");
      set_ctrl(1'b1, 6'b010000);
      rd(7, 64'd0, 1'b1, "rlock_w7");
      rd(W_VIOL, 64'd2, 1'b0, "viol_two");
      wr(W_VIOL, 64'd5, 1'b0, "viol_clear");
      rd(W_VIOL, 64'd0, 1'b0, "viol_zero");
      set_ctrl(1'b1, 6'b000000);
      wr(5, 64'hDEAD_BEEF_0000_0077, 1'b0, "write_w5_wide");
      rd(5, 64'h77, 1'b0, "read_w5_trunc");

      wr(2, 64'h55, 1'b0, "write_w2");
      rd(W_STATUS, 64'd1, 1'b0, "status_before_revert");
      wr(W_CMD, 64'd2, 1'b0, "revert");
      rd(2, 64'hFFFF_FFFF, 1'b0, "w2_reverted");
      rd(4, 64'hFFFF_FFFF, 1'b0, "w4_reverted");
      wr(2, 64'h55, 1'b0, "rewrite_w2");
      wr(3, 64'h66, 1'b0, "write_w3");
      set_acc(2, 32'h55);
      set_acc(3, 32'h66);
      wr(W_CMD, 64'd3, 1'b0, "commit_and_revert");
      rd(2, 64'h55, 1'b0, "w2_after_cmd3");
      rd(W_STATUS, 64'd0, 1'b0, "status_after_cmd3");

      wr(0, 64'h22, 1'b0, "write_w0");
      wr(W_STICKY, 64'd1, 1'b0, "sticky_set");
      wr(0, 64'h11, 1'b1, "sticky_w0");
      wr(W_STICKY, 64'd0, 1'b0, "sticky_write0");
      rd(W_STICKY, 64'd1, 1'b0, "sticky_held");
      wr(4, 64'h1234, 1'b0, "write_w4_again");
      set_acc(4, 32'h1234);
      wr(W_CMD, 64'd1, 1'b0, "commit_sticky");
      rd(0, 64'h22, 1'b0, "w0_shadow_kept");
      rd(W_STATUS, 64'd1, 1'b0, "status_locked_pending");
      rd(W_VIOL, 64'd1, 1'b0, "viol_sticky");

      set_ctrl(1'b0, 6'b000000);
      wr(4, 64'h999, 1'b1, "disabled_write");
      rd(4, 64'd0, 1'b1, "disabled_read");
      set_ctrl(1'b1, 6'b000000);
      rd(4, 64'h1234, 1'b0, "w4_after_disabled");
      rd(W_VIOL, 64'd1, 1'b0, "viol_no_incr");
      rd('h90, 64'd0, 1'b1, "unmapped_read");
      wr(W_STATUS, 64'd1, 1'b1, "status_write");
      rd(W_CMD, 64'd0, 1'b0, "cmd_read");
      rd(W_STATUS, 64'd1, 1'b0, "status_unchanged");
      rd(W_VIOL, 64'd1, 1'b0, "viol_still_one");
      set_ctrl(1'b1, 6'b101010);
      wr(W_CMD, 64'd1, 1'b0, "cmd_all_locked");
      set_ctrl(1'b1, 6'b000000);

      @(negedge clk_i);
      req_i  = 1'b1;
      we_i   = 1'b0;
      addr_i = 64'(4) << 3;
      @(posedge clk_i);
      #2;
      rst_i = 1'b1;
      req_i = 1'b0;
      exp_acc = '1;
      @(negedge clk_i);
      chk("rst_drops_rvalid", AW'(rvalid_o), AW'(1'b0));
      chk("rst_acc", acc_ctrl_o, {AW{1'b1}});
      @(negedge clk_i);
      rst_i = 1'b0;

      rd(0, 64'hFFFF_FFFF, 1'b0, "post_rst_w0");
      rd(W_STICKY, 64'd0, 1'b0, "post_rst_sticky");
      rd(W_VIOL, 64'd0, 1'b0, "post_rst_viol");
      rd(4, 64'hFFFF_FFFF, 1'b0, "post_rst_w4");
      @(negedge clk_i);
      req_i = 1'b0;
      repeat (3) @(negedge clk_i);
      chk("responses_outstanding", AW'(sb_q.size()), AW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/acct_table_ctrl.md
# acct_table_ctrl

Parametrised access-control table with double-buffered (shadow/active) entries, per-group read/write locks, sticky write-once locks and a violation counter. Software programs shadow entries over a simple request/response register port. An explicit commit copies them atomically to the active bank, which drives the peripheral access-control vector. It sits between the SoC register crossbar and the peripheral access gates, as the next generation of the access-control table.

## Interface
- NB_PERIPHERALS, 9: number of table entries, range 1..64.
- ENTRY_W, 32: bits per entry, range 1..64.
- GROUP_SIZE, 3: consecutive entries sharing one lock pair; NB_GROUPS = ceil(NB_PERIPHERALS/GROUP_SIZE) (derived, ≤16).
- ADDR_W, 64: register-port address width.
- clk_i  in  1  clock; all state is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- acct_ctrl_i  in  1  port enable; 0 = every request is rejected.
- reglk_ctrl_i  in  2*NB_GROUPS  bit 2g = read lock of group g, bit 2g+1 = write lock of group g.
- req_i  in  1  request valid; a request is accepted every cycle (no stall).
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  ADDR_W  byte address; word index = addr_i[10:3].
- wdata_i  in  64  write data.
- rvalid_o  out  1  response valid, exactly one cycle after each accepted req_i.
- rdata_o  out  64  read data, zero-extended; 0 for writes and errors.
- err_o  out  1  error flag, qualified by rvalid_o.
- acc_ctrl_o  out  NB_PERIPHERALS*ENTRY_W  active bank; entry i occupies bits [i*ENTRY_W +: ENTRY_W].

## Operation
- Word map:
  - 0..NB_PERIPHERALS-1: SHADOW[i], read/write.
  - 0x80: CMD, write-only; bit0 = commit, bit1 = revert; reads return 0.
  - 0x81: STICKY, bits [NB_GROUPS-1:0]; write-1-sets; cleared only by reset.
  - 0x82: VIOL_CNT, 16 bits; a read returns the count; any write clears it.
  - 0x83: STATUS, read-only; bit0 = pending (some SHADOW ≠ ACTIVE).
  - Any other index is an error.
- Effective write lock of group g = reglk_ctrl_i[2g+1] | STICKY[g]. Effective read lock = reglk_ctrl_i[2g].
- SHADOW write to a write-locked group: entry unchanged; err_o = 1; VIOL_CNT increments.
- SHADOW read from a read-locked group: rdata_o = 0; err_o = 1; VIOL_CNT increments.
- Unmapped access, write to STATUS, or acct_ctrl_i = 0: err_o = 1; no state change; no VIOL_CNT increment.
- SHADOW writes take wdata_i[ENTRY_W-1:0]; upper bits are ignored.
- Commit: ACTIVE[i] <= SHADOW[i] for every entry whose group is not write-locked. Locked entries keep ACTIVE and SHADOW unchanged.
- Revert: SHADOW[i] <= ACTIVE[i] for every entry whose group is not write-locked.
- CMD with both bit0 and bit1 set: commit wins, revert is ignored. CMD writes never error, even if every group is locked.
- VIOL_CNT saturates at 0xFFFF.
- A violation in the same cycle as a VIOL_CNT clear write is impossible (single port).
- Reset values: SHADOW = ACTIVE = all ones (deny-all); STICKY = 0; VIOL_CNT = 0; rvalid_o = 0; rdata_o = 0; err_o = 0. Therefore acc_ctrl_o = all ones.

## Timing
- The request is sampled at edge N. rvalid_o, rdata_o and err_o are registered and valid during cycle N+1, for one cycle only.
- Back-to-back requests give back-to-back responses.
- A SHADOW write at edge N is visible to a read accepted at edge N+1.
- A commit at edge N updates ACTIVE, and therefore acc_ctrl_o, at edge N.
  - acc_ctrl_o changes only on a commit edge or on reset.
  - acc_ctrl_o is driven directly from flops, never combinationally from bus inputs.
- STATUS.pending is computed combinationally from the registers and read like any register; it reflects state after the previous edge.
- Locks are sampled at the request edge. A reglk change takes effect for the next accepted request.
- Reset asserted mid-transaction: all state clears immediately and asynchronously. The pending response is dropped (rvalid_o = 0). The first request after deassertion behaves normally.

## Test plan
- Reset, then read word 0 -> rvalid_o = 1 one cycle later, rdata_o = 0xFFFFFFFF, err_o = 0; acc_ctrl_o = all ones.
- Write 0x0000_00A5 to word 1, read STATUS -> 1. Write CMD = 1 -> acc_ctrl_o[63:32] = 0xA5 after that edge; STATUS reads 0.
- Set reglk_ctrl_i[3] (group 1 write lock). Write word 4 -> err_o = 1, word 4 unchanged, VIOL_CNT reads 1. Clear reglk; same write -> err_o = 0.
- Write STICKY = 0x1, then write word 0 -> err_o = 1. Write STICKY = 0 -> STICKY still reads 0x1. Commit -> ACTIVE[0] unchanged while other groups update.
- Write word 2 = 0x55, CMD = 2 (revert) -> word 2 reads 0xFFFFFFFF. Then CMD = 3 -> commit applied.
- acct_ctrl_i = 0, write word 0 -> err_o = 1, no state change. Read word 0x90 with the port enabled -> err_o = 1, rdata_o = 0. Assert rst_i during a read -> no rvalid_o.
